izigzag_buffer: RTL and testbench
=================================

# izigzag_buffer

Inverse zigzag reorder buffer for the decode path. It accepts a stream of COL×ROW coefficients in zigzag scan order and emits each block in raster order (x fastest, then y). Ping-pong storage lets block N+1 be written while block N is read out. It sits between the entropy/run-length decoder and the dequantiser/IDCT, and undoes the forward zigzag scan.

## Interface
- COL, 8, block width in coefficients (≥2)
- ROW, 8, block height in coefficients (≥2)
- DW, 12, coefficient width in bits
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  DW  coefficient, zigzag order
- in_valid  in  1  in_data valid
- in_ready  out  1  buffer can accept; transfer when in_valid && in_ready
- out_data  out  DW  coefficient, raster order
- out_x  out  $clog2(COL)  column of out_data
- out_y  out  $clog2(ROW)  row of out_data
- out_last  out  1  out_data is the block's final raster entry (COL-1, ROW-1)
- out_valid  out  1  out_* valid
- out_ready  in  1  sink accepts; transfer when out_valid && out_ready

## Operation
- Storage: two banks of COL*ROW × DW words. Each bank has a full flag. Pointers: wbank and rbank.
- Write side: a zigzag position (zx, zy) starts at (0,0). On each input transfer, in_data is written to wbank[zy*COL+zx], then the position steps:
  - (zx+zy) even: if zx==COL-1, go down; else if zy==0, go right; else go up-right.
  - (zx+zy) odd: if zy==ROW-1, go right; else if zx==0, go down; else go down-left.
  - At (COL-1, ROW-1): set full[wbank], toggle wbank, position returns to (0,0).
- in_ready = !full[wbank], combinational from flags only. It does not depend on in_valid.
- Read side: a raster counter (rx, ry) starts at (0,0). A read fires when full[rbank] && (out_ready || !out_valid).
  - The read captures rbank[ry*COL+rx] into the out_data register. rx/ry go to out_x/out_y, and out_last = (rx==COL-1 && ry==ROW-1). out_valid is then set.
  - The counter then advances rx first, wrapping to ry+1.
  - A read at the last entry clears full[rbank], toggles rbank, and resets the counter.
- If no read fires and out_ready is high, out_valid clears. While out_valid && !out_ready, all out_* hold stable.
- Set and clear of full flags in the same cycle target different banks, so both take effect.
- Reset mid-operation discards any partial block and both banks' contents. Bank RAM is not cleared.

## Timing
- Reset values:
  - in_ready=1
  - out_valid=0, out_last=0, out_data=0, out_x=0, out_y=0
  - both full flags=0, wbank=rbank=0, both counters=(0,0)
- Latency: if the last input of a block is accepted at edge E with the read side idle, out_valid is high after edge E+1 with raster (0,0).
- Throughput: one input and one output per cycle. With out_ready held high, back-to-back blocks stream with in_ready never dropping.
- Memory uses a synchronous read. The out_data register is the RAM output register, enabled by a read firing.
- Backpressure: with out_ready low, at most 2 complete blocks are accepted. in_ready drops after the 2·COL·ROW-th transfer.

## Structure
- Shared package jpeg_pkg holds:
  - default block constants BLK_COL=8, BLK_ROW=8, COEF_W=12
  - function zz_next(x, y) implementing the step rule above, shared with the forward scan
- Sub-module zz_pos_gen: holds the (x, y) register, with inputs advance and clear, and outputs x, y, and last. It applies zz_next. It is instantiated for the write side.
- Top level contains: the two-bank RAM (inferred), full flags, bank pointers, raster counter, and output register.

## Test plan
- Single block, 8×8: in_data = zigzag index 0..63, out_ready=1.
  - Row 0 out_data must read 0,1,5,6,14,15,27,28.
  - Row 1 must read 2,4,7,13,16,26,29,42.
  - (7,7) must read 63, with out_last only on that entry.
  - out_valid must rise one cycle after the 64th input.
- Backpressure: out_ready=0, in_valid=1 continuously.
  - in_ready drops after exactly 128 transfers.
  - Then raise out_ready: 128 outputs emerge in raster order, block 0 then block 1.
- Streaming: 3 blocks back to back with out_ready=1.
  - in_ready stays 1 throughout.
  - 192 outputs arrive, each block correctly reordered.
- Random out_ready toggling during readout: out_data, out_x and out_y hold stable whenever out_valid && !out_ready. No entry is dropped or duplicated.
- Reset mid-block: accept 30 samples, pulse rst, then send a full block.
  - Output contains only the new block, correctly ordered.
  - All outputs read their reset values during rst.
- COL=4, ROW=2: input 0..7.
  - Raster output must be 0,1,4,5,2,3,6,7.
  - out_last only on (3,1).

Source files
------------

// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared block constants and the zigzag step rule used by forward and inverse scans.
package jpeg_pkg;
  localparam int BLK_COL = 8;
  localparam int BLK_ROW = 8;
  localparam int COEF_W = 12;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } zz_pos_t;
  function automatic zz_pos_t zz_next(input int x, input int y, input int col, input int row);
    zz_pos_t p;
    int nx;
    int ny;
    if (((x ^ y) & 1) == 0) begin
      nx = x == col - 1 ? x : x + 1;
      ny = x == col - 1 ? y + 1 : y == 0 ? y : y - 1;
    end else begin
      nx = y == row - 1 ? x + 1 : x == 0 ? x : x - 1;
      ny = y == row - 1 ? y : y + 1;
    end
    p.x = 16'(nx);
    p.y = 16'(ny);
    return p;
  endfunction
endpackage

// File: rtl/izigzag_buffer_if.sv
// izigzag_buffer_if: zigzag-order input stream and raster-order output stream.
interface izigzag_buffer_if #(parameter int COL = 8, parameter int ROW = 8, parameter int DW = 12);
  logic [DW-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [DW-1:0] out_data;
  logic [$clog2(COL)-1:0] out_x;
  logic [$clog2(ROW)-1:0] out_y;
  logic out_last;
  logic out_valid;
  logic out_ready;
  modport master(output in_data, in_valid, out_ready,
                 input in_ready, out_data, out_x, out_y, out_last, out_valid);
  modport slave(input in_data, in_valid, out_ready,
                output in_ready, out_data, out_x, out_y, out_last, out_valid);
endinterface

// File: rtl/zz_pos_gen.sv
// zz_pos_gen: zigzag scan position register stepping by zz_next, wrapping to (0,0) after the last entry.
module zz_pos_gen import jpeg_pkg::*; #(
  parameter int COL = BLK_COL,
  parameter int ROW = BLK_ROW
) (
  input  logic clk,
  input  logic rst,
  input  logic advance_i,
  input  logic clear_i,
  output logic [$clog2(COL)-1:0] x_o,
  output logic [$clog2(ROW)-1:0] y_o,
  output logic last_o
);
  localparam int XW = $clog2(COL);
  localparam int YW = $clog2(ROW);
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  zz_pos_t nxt;
  assign last_o = x_q == XW'(COL - 1) && y_q == YW'(ROW - 1);
  always_comb begin
    nxt = zz_next(int'(x_q), int'(y_q), COL, ROW);
    x_d = clear_i || (advance_i && last_o) ? '0 : advance_i ? XW'(nxt.x) : x_q;
    y_d = clear_i || (advance_i && last_o) ? '0 : advance_i ? YW'(nxt.y) : y_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  assign x_o = x_q;
  assign y_o = y_q;
endmodule

// File: rtl/izigzag_buffer.sv
// izigzag_buffer: ping-pong buffer reordering zigzag-scanned coefficient blocks into raster order.
module izigzag_buffer import jpeg_pkg::*; #(
  parameter int COL = BLK_COL,
  parameter int ROW = BLK_ROW,
  parameter int DW = COEF_W
) (
  input logic clk,
  input logic rst,
  izigzag_buffer_if.slave s_io
);
  localparam int N = COL * ROW;
  localparam int AW = $clog2(N);
  localparam int XW = $clog2(COL);
  localparam int YW = $clog2(ROW);
  logic [DW-1:0] mem [2][N];
  logic [1:0] full_q, full_d;
  logic wbank_q, wbank_d, rbank_q, rbank_d;
  logic [XW-1:0] rx_q, rx_d, zx, ox_q;
  logic [YW-1:0] ry_q, ry_d, zy, oy_q;
  logic [DW-1:0] odata_q;
  logic olast_q, ovalid_q, zlast, wr, rd, rlast;
  logic [AW-1:0] waddr, raddr;
  zz_pos_gen #(.COL(COL), .ROW(ROW)) u_pos (
    .clk(clk), .rst(rst), .advance_i(wr), .clear_i(1'b0),
    .x_o(zx), .y_o(zy), .last_o(zlast)
  );
  assign s_io.in_ready = !full_q[wbank_q];
  assign wr = s_io.in_valid && !full_q[wbank_q];
  assign rd = full_q[rbank_q] && (s_io.out_ready || !ovalid_q);
  assign rlast = rx_q == XW'(COL - 1) && ry_q == YW'(ROW - 1);
  assign waddr = AW'(int'(zy) * COL + int'(zx));
  assign raddr = AW'(int'(ry_q) * COL + int'(rx_q));
  // A write can only target a non-full bank and a read a full one, so set and clear never collide.
  always_comb begin
    full_d = full_q;
    if (wr && zlast) full_d[wbank_q] = 1'b1;
    if (rd && rlast) full_d[rbank_q] = 1'b0;
    wbank_d = wbank_q ^ (wr && zlast);
    rbank_d = rbank_q ^ (rd && rlast);
    rx_d = !rd ? rx_q : rx_q == XW'(COL - 1) ? '0 : rx_q + 1'b1;
    ry_d = !rd || rx_q != XW'(COL - 1) ? ry_q : rlast ? '0 : ry_q + 1'b1;
  end
  always_ff @(posedge clk)
    if (wr) mem[wbank_q][waddr] <= s_io.in_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      full_q <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      rx_q <= '0;
      ry_q <= '0;
      odata_q <= '0;
      ox_q <= '0;
      oy_q <= '0;
      olast_q <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      full_q <= full_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      rx_q <= rx_d;
      ry_q <= ry_d;
      if (rd) begin
        odata_q <= mem[rbank_q][raddr];
        ox_q <= rx_q;
        oy_q <= ry_q;
        olast_q <= rlast;
        ovalid_q <= 1'b1;
      end else if (s_io.out_ready) ovalid_q <= 1'b0;
    end
  assign s_io.out_data = odata_q;
  assign s_io.out_x = ox_q;
  assign s_io.out_y = oy_q;
  assign s_io.out_last = olast_q;
  assign s_io.out_valid = ovalid_q;
endmodule

// File: tb/tb_izigzag_buffer.sv
// tb_izigzag_buffer: random and directed stimulus checked against a diagonal-walk reorder model.
module tb_izigzag_buffer;
  typedef struct {
    logic [11:0] d;
    int x;
    int y;
    logic l;
  } ent_t;
  logic clk = 0;
  logic rst = 1;
  int total = 0;
  int bad = 0;
  izigzag_buffer_if #(.COL(8), .ROW(8), .DW(12)) a ();
  izigzag_buffer_if #(.COL(4), .ROW(2), .DW(12)) b ();
  izigzag_buffer #(.COL(8), .ROW(8), .DW(12)) u_a (.clk(clk), .rst(rst), .s_io(a));
  izigzag_buffer #(.COL(4), .ROW(2), .DW(12)) u_b (.clk(clk), .rst(rst), .s_io(b));
  always #5 clk = ~clk;

  ent_t exq[$];
  logic [11:0] blk [64];
  logic [11:0] got [64];
  int nin = 0, nout = 0, nlast = 0;
  bit hold = 0;
  logic [19:0] snap;
  logic [11:0] gotb_d [8];
  logic gotb_l [8];
  int gotb_x [8], gotb_y [8];
  int nb = 0;
  bit rnd_on;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Zigzag walks anti-diagonals x+y=s; even diagonals run with x rising, odd ones with x falling.
  function automatic int raster_of(input int k, input int col, input int row);
    int n, lo, hi, x;
    n = 0;
    for (int s = 0; s < col + row - 1; s++) begin
      lo = s - row + 1 > 0 ? s - row + 1 : 0;
      hi = s < col - 1 ? s : col - 1;
      for (int i = 0; i <= hi - lo; i++) begin
        x = (s % 2 == 0) ? lo + i : hi - i;
        if (n == k) return (s - x) * col + x;
        n++;
      end
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    ent_t e;
    if (rst) begin
      nin = 0;
      exq.delete();
      hold = 0;
    end else begin
      if (hold) check("hold_stable", {a.out_valid, a.out_data, a.out_x, a.out_y, a.out_last}, snap);
      if (a.out_valid && a.out_ready) begin
        if (exq.size() == 0) check("extra_output", 1, 0);
        else begin
          e = exq.pop_front();
          check("out_entry", {a.out_data, 3'(a.out_x), 3'(a.out_y), a.out_last},
                {e.d, 3'(e.x), 3'(e.y), e.l});
        end
        got[int'(a.out_y) * 8 + int'(a.out_x)] = a.out_data;
        nout++;
        if (a.out_last) nlast++;
      end
      hold = a.out_valid && !a.out_ready;
      snap = {a.out_valid, a.out_data, a.out_x, a.out_y, a.out_last};
      if (a.in_valid && a.in_ready) begin
        blk[raster_of(nin, 8, 8)] = a.in_data;
        nin++;
        if (nin == 64) begin
          for (int r = 0; r < 64; r++) begin
            e.d = blk[r]; e.x = r % 8; e.y = r / 8; e.l = (r == 63);
            exq.push_back(e);
          end
          nin = 0;
        end
      end
      if (b.out_valid && b.out_ready && nb < 8) begin
        gotb_d[nb] = b.out_data;
        gotb_l[nb] = b.out_last;
        gotb_x[nb] = int'(b.out_x);
        gotb_y[nb] = int'(b.out_y);
        nb++;
      end
    end
  end

  task automatic push(input logic [11:0] d);
    int t = 0;
    a.in_valid = 1;
    a.in_data = d;
    while (!a.in_ready && t < 1000) begin @(posedge clk); #1; t++; end
    if (t >= 1000) check("push_timeout", 1, 0);
    @(posedge clk); #1;
    a.in_valid = 0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exq.size() != 0 || nin != 0 || a.out_valid) && t < 2000) begin @(posedge clk); #1; t++; end
    check("drain_timeout", t >= 2000, 0);
  endtask

  task automatic check_reset();
    check("rst_in_ready", a.in_ready, 1);
    check("rst_out_valid", a.out_valid, 0);
    check("rst_out_last", a.out_last, 0);
    check("rst_out_data", a.out_data, 0);
    check("rst_out_xy", {a.out_x, a.out_y}, 0);
    check("rst_b_outs", {b.out_valid, b.out_last, b.out_data, b.out_x, b.out_y, b.in_ready}, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, base;
    logic [11:0] row0 [8], row1 [8], exp4 [8];
    row0 = '{0, 1, 5, 6, 14, 15, 27, 28};
    row1 = '{2, 4, 7, 13, 16, 26, 29, 42};
    exp4 = '{0, 1, 4, 5, 2, 3, 6, 7};
    a.in_valid = 0; a.in_data = 0; a.out_ready = 1;
    b.in_valid = 0; b.in_data = 0; b.out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 64; k++) push(12'(k));
    @(negedge clk);
    check("valid_before_latency", a.out_valid, 0);
    @(negedge clk);
    check("valid_after_latency", {a.out_valid, a.out_x, a.out_y, a.out_data}, {1'b1, 18'd0});
    @(posedge clk); #1;
    drain();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("row0_%0d", i), got[i], row0[i]);
      check($sformatf("row1_%0d", i), got[8 + i], row1[i]);
    end
    check("corner_77", got[63], 63);
    check("single_last_count", nlast, 1);
    check("single_out_count", nout, 64);

    a.out_ready = 0;
    n = 0;
    while (a.in_ready && n < 200) begin
      a.in_valid = 1; a.in_data = 12'($urandom);
      @(posedge clk); #1;
      n++;
    end
    a.in_valid = 0;
    check("bp_accept_count", n, 128);
    repeat (5) @(posedge clk);
    #1;
    check("bp_in_ready_low", a.in_ready, 0);
    base = nout;
    a.out_ready = 1;
    drain();
    check("bp_out_count", nout - base, 128);

    base = nout;
    for (int i = 0; i < 192; i++) begin
      check("stream_in_ready", a.in_ready, 1);
      push(12'($urandom));
    end
    drain();
    check("stream_out_count", nout - base, 192);

    base = nout;
    rnd_on = 1;
    fork
      begin
        for (int i = 0; i < 256; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          push(12'($urandom));
        end
        rnd_on = 0;
      end
      begin
        while (rnd_on) begin
          a.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    a.out_ready = 1;
    drain();
    check("random_out_count", nout - base, 256);

    for (int i = 0; i < 30; i++) push(12'($urandom_range(100, 4000)));
    rst = 1;
    #1;
    check_reset();
    @(posedge clk); #1;
    check_reset();
    rst = 0;
    base = nout;
    for (int k = 0; k < 64; k++) push(12'(k));
    drain();
    check("post_reset_count", nout - base, 64);
    check("post_reset_row1_x0", got[8], 2);
    check("post_reset_corner", got[63], 63);

    for (int k = 0; k < 8; k++) begin
      b.in_valid = 1; b.in_data = 12'(k);
      @(posedge clk); #1;
    end
    b.in_valid = 0;
    n = 0;
    while (nb < 8 && n < 200) begin @(posedge clk); #1; n++; end
    check("b_out_count", nb, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b_data_%0d", i), gotb_d[i], exp4[i]);
      check($sformatf("b_last_%0d", i), gotb_l[i], i == 7);
      check($sformatf("b_xy_%0d", i), {gotb_x[i], gotb_y[i]}, {i % 4, i / 4});
    end
    check("model_queue_empty", exq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
